// File: rtl/prbs9_tx_gen.sv
// PRBS9 (x^9+x^5+1) transmit source with a symbol-rate strobe; restarts from SEED on every enable.
// Optional one-shot bit-error injection is compiled in with `define PRBS_ERR_INJECT_EN.
module prbs9_tx_gen #(
  parameter int unsigned          PRBS_LEN = 9,
  parameter logic [PRBS_LEN-1:0]  SEED     = 9'h1AA,
  parameter int unsigned          DIV      = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_enable,
  input  logic                i_restart,
`ifdef PRBS_ERR_INJECT_EN
  input  logic                i_inject,
  output logic [7:0]          o_inj_cnt,
`endif
  output logic                o_bit,
  output logic                o_valid,
  output logic                o_seq_start,
  output logic [PRBS_LEN-1:0] o_bit_idx,
  output logic                o_running
);

  localparam int unsigned           CNT_W   = $clog2(DIV);
  localparam logic [CNT_W-1:0]      CNT_MAX = CNT_W'(DIV - 1);
  localparam logic [PRBS_LEN-1:0]   IDX_MAX = PRBS_LEN'((1 << PRBS_LEN) - 2);

  typedef enum logic [1:0] {StIdle, StLoad, StRun} state_e;

  state_e              r_state;
  logic [PRBS_LEN-1:0] r_lfsr;
  logic [CNT_W-1:0]    r_div_cnt;
  logic [PRBS_LEN-1:0] r_bit_idx;

  logic w_valid;
  logic w_adv;

  assign w_valid = (r_state == StRun) && (r_div_cnt == CNT_MAX);
  // Disable and restart both suppress the advance on the strobe edge.
  assign w_adv   = w_valid && i_enable && !i_restart;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StIdle;
      r_lfsr    <= SEED;
      r_div_cnt <= '0;
      r_bit_idx <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (i_enable) r_state <= StLoad;
        end
        StLoad: begin
          r_lfsr    <= SEED;
          r_div_cnt <= '0;
          r_bit_idx <= '0;
          r_state   <= i_enable ? StRun : StIdle;
        end
        StRun: begin
          if (!i_enable) begin
            r_state <= StIdle;
          end else if (i_restart) begin
            r_state <= StLoad;
          end else begin
            r_div_cnt <= (r_div_cnt == CNT_MAX) ? '0 : r_div_cnt + 1'b1;
            if (w_adv) begin
              r_lfsr    <= {r_lfsr[PRBS_LEN-2:0], r_lfsr[PRBS_LEN-1] ^ r_lfsr[PRBS_LEN-5]};
              r_bit_idx <= (r_bit_idx == IDX_MAX) ? '0 : r_bit_idx + 1'b1;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_valid     = w_valid;
  assign o_seq_start = w_valid && (r_bit_idx == '0);
  assign o_bit_idx   = r_bit_idx;
  assign o_running   = (r_state == StRun);

`ifdef PRBS_ERR_INJECT_EN
  logic       r_inj_arm;
  logic       r_inj_act;
  logic [7:0] r_inj_cnt;
  logic       w_present;

  // A new symbol reaches o_bit on every advance and when LOAD reinstalls bit 0.
  assign w_present = (r_state == StLoad) || w_adv;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_inj_arm <= 1'b0;
      r_inj_act <= 1'b0;
      r_inj_cnt <= '0;
    end else begin
      if (w_present) begin
        r_inj_act <= r_inj_arm;
        r_inj_arm <= 1'b0;
      end
      if (i_inject && !r_inj_arm) begin
        r_inj_arm <= 1'b1;
        if (r_inj_cnt != 8'hFF) r_inj_cnt <= r_inj_cnt + 8'd1;
      end
    end
  end

  assign o_bit     = r_lfsr[PRBS_LEN-1] ^ r_inj_act;
  assign o_inj_cnt = r_inj_cnt;
`else
  assign o_bit     = r_lfsr[PRBS_LEN-1];
`endif

endmodule

// File: tb/tb_prbs9_tx_gen.sv
// Self-checking bench for prbs9_tx_gen against a sequence-table reference model.
// Exercises the injection feature too when PRBS_ERR_INJECT_EN is defined.
module tb_prbs9_tx_gen;

  localparam int DIV = 4;
  localparam int PER = 511;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_enable;
  logic       i_restart;
  logic       o_bit;
  logic       o_valid;
  logic       o_seq_start;
  logic [8:0] o_bit_idx;
  logic       o_running;
`ifdef PRBS_ERR_INJECT_EN
  logic       i_inject;
  logic [7:0] o_inj_cnt;
`endif

  always #5 clk = ~clk;

  prbs9_tx_gen dut (
    .clk         (clk),
    .rst         (rst),
    .i_enable    (i_enable),
    .i_restart   (i_restart),
`ifdef PRBS_ERR_INJECT_EN
    .i_inject    (i_inject),
    .o_inj_cnt   (o_inj_cnt),
`endif
    .o_bit       (o_bit),
    .o_valid     (o_valid),
    .o_seq_start (o_seq_start),
    .o_bit_idx   (o_bit_idx),
    .o_running   (o_running)
  );

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Reference: the 511-bit output sequence, from s[n+9] = s[n] ^ s[n+4].
  bit seq [PER];

  // Model: mode 0 idle, 1 load, 2 run; m_cnt counts run cycles, m_idx the symbol on o_bit.
  int m_mode, m_cnt, m_idx;
  bit m_arm, m_act;
  int m_icnt;

  function automatic bit m_valid();
    return (m_mode == 2) && ((m_cnt % DIV) == DIV - 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit v;
    v = m_valid();
    if (rst) begin
      m_mode = 0; m_cnt = 0; m_idx = 0; m_arm = 0; m_act = 0; m_icnt = 0;
    end else begin
`ifdef PRBS_ERR_INJECT_EN
      begin
        bit pres, old_arm;
        pres    = (m_mode == 1) || (m_mode == 2 && i_enable && !i_restart && v);
        old_arm = m_arm;
        if (pres) begin m_act = old_arm; m_arm = 0; end
        if (i_inject && !old_arm) begin
          m_arm = 1;
          if (m_icnt < 255) m_icnt++;
        end
      end
`endif
      case (m_mode)
        0: if (i_enable) m_mode = 1;
        1: begin m_idx = 0; m_cnt = 0; m_mode = i_enable ? 2 : 0; end
        default: begin
          if (!i_enable) m_mode = 0;
          else if (i_restart) m_mode = 1;
          else begin
            if (v) m_idx = (m_idx + 1) % PER;
            m_cnt++;
          end
        end
      endcase
    end
  endtask

  task automatic check_all();
    chk("o_running", o_running, m_mode == 2);
    chk("o_valid", o_valid, m_valid());
    chk("o_seq_start", o_seq_start, m_valid() && (m_idx == 0));
    chk("o_bit_idx", o_bit_idx, m_idx);
    chk("o_bit", o_bit, seq[m_idx] ^ m_act);
`ifdef PRBS_ERR_INJECT_EN
    chk("o_inj_cnt", o_inj_cnt, m_icnt);
`endif
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic run_until(input int idx, input bit need_v, input string tag);
    int k;
    for (k = 0; k < 3000; k++) begin
      if (m_idx == idx && (!need_v || m_valid())) break;
      tick();
    end
    if (k == 3000) begin
      n_total++;
      n_fail++;
      $error("FAIL %s: timeout, observed idx %0d expected idx %0d", tag, o_bit_idx, idx);
    end
  endtask

  initial begin
    logic [8:0] sd;
    bit         got [PER];
    logic [8:0] first9;
    logic [3:0] first4;
    int         nv, ones, run, maxrun;

    sd = 9'h1AA;
    for (int i = 0; i < 9; i++) seq[i] = sd[8-i];
    for (int n = 0; n + 9 < PER; n++) seq[n+9] = seq[n] ^ seq[n+4];

    m_mode = 0; m_cnt = 0; m_idx = 0; m_arm = 0; m_act = 0; m_icnt = 0;
    rst = 1'b1; i_enable = 1'b0; i_restart = 1'b0;
`ifdef PRBS_ERR_INJECT_EN
    i_inject = 1'b0;
`endif

    // Reset and first bits.
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("reset_bit", o_bit, 1'b1);
    i_enable = 1'b1;
    tick();
    chk("run_lat1", o_running, 1'b0);
    tick();
    chk("run_lat2", o_running, 1'b1);

    // Full period plus wrap.
    nv = 0;
    for (int c = 0; c < PER * DIV + 4 * DIV && nv < 512; c++) begin
      tick();
      if (m_valid()) begin
        if (nv < PER) got[nv] = o_bit;
        if (nv == PER) begin
          chk("wrap_seq_start", o_seq_start, 1'b1);
          chk("wrap_bit", o_bit, 1'b1);
          chk("wrap_idx", o_bit_idx, 0);
        end
        nv++;
      end
    end
    chk("period_valids", nv, 512);
    for (int i = 0; i < 9; i++) first9[8-i] = got[i];
    chk("first9", first9, 9'b110101010);
    ones = 0; run = 0; maxrun = 0;
    for (int i = 0; i < 2 * PER; i++) begin
      if (i < PER && got[i]) ones++;
      if (got[i % PER]) run = 0;
      else begin run++; if (run > maxrun) maxrun = run; end
    end
    chk("ones_count", ones, 256);
    chk("max_zero_run", maxrun, 8);

    // Disable mid-sequence, hold, then re-enable from SEED.
    run_until(37, 1'b0, "wait_idx37");
    repeat ($urandom_range(0, 2)) tick();
    i_enable = 1'b0;
    tick();
    chk("dis_valid", o_valid, 1'b0);
    repeat ($urandom_range(3, 10)) tick();
    chk("dis_hold_idx", o_bit_idx, 37);
    chk("dis_hold_bit", o_bit, seq[37]);
    i_enable = 1'b1;
    tick();
    tick();
    chk("reen_idx", o_bit_idx, 0);
    nv = 0;
    for (int c = 0; c < 8 * DIV && nv < 4; c++) begin
      tick();
      if (m_valid()) begin first4[3-nv] = o_bit; nv++; end
    end
    chk("reen_first4", first4, 4'b1101);

    // Restart during a strobe cycle at bit 100.
    run_until(100, 1'b1, "wait_idx100");
    i_restart = 1'b1;
    tick();
    i_restart = 1'b0;
    chk("restart_noadv", o_bit_idx, 100);
    chk("restart_load", o_running, 1'b0);
    tick();
    chk("restart_idx0", o_bit_idx, 0);
    run_until(3, 1'b0, "wait_idx3");

    // Restart with disable: idle wins; restart in idle ignored.
    repeat ($urandom_range(1, 6)) tick();
    i_restart = 1'b1; i_enable = 1'b0;
    tick();
    chk("conflict_idle", o_running, 1'b0);
    tick();
    i_restart = 1'b0;
    tick();
    chk("idle_restart_ign", o_running, 1'b0);

    // Reset while a strobe is high.
    i_enable = 1'b1;
    run_until(2, 1'b1, "wait_idx2");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", o_valid, 1'b0);
    chk("mid_rst_bit", o_bit, 1'b1);
    chk("mid_rst_idx", o_bit_idx, 0);
    chk("mid_rst_run", o_running, 1'b0);

    // Random enable/restart traffic.
    repeat (600) begin
      i_enable  = ($urandom_range(0, 39) != 0);
      i_restart = ($urandom_range(0, 59) == 0);
`ifdef PRBS_ERR_INJECT_EN
      i_inject  = ($urandom_range(0, 29) == 0);
`endif
      tick();
    end
    i_restart = 1'b0;
`ifdef PRBS_ERR_INJECT_EN
    i_inject  = 1'b0;

    // Single injection at bit 5 lands on bit 6 only.
    rst = 1'b1; i_enable = 1'b0;
    tick();
    rst = 1'b0; i_enable = 1'b1;
    run_until(5, 1'b0, "wait_inj5");
    tick();
    i_inject = 1'b1;
    tick();
    i_inject = 1'b0;
    run_until(6, 1'b0, "wait_inj6");
    chk("inj_bit6", o_bit, !seq[6]);
    chk("inj_cnt1", o_inj_cnt, 1);
    run_until(7, 1'b0, "wait_inj7");
    chk("inj_bit7", o_bit, seq[7]);

    // Counter saturation.
    for (int k = 0; k < 300; k++) begin
      i_inject = 1'b1;
      tick();
      i_inject = 1'b0;
      repeat (DIV + 1) tick();
    end
    chk("inj_sat", o_inj_cnt, 255);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
